// File: rtl/epp_reg_arbiter_if.sv
// Request/ack bundle for the shared register-file port: one EPP requester,
// two fabric requesters and the arbiter busy flag.
interface epp_reg_arbiter_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
);
  logic              epp_req;
  logic              epp_we;
  logic [ADDR_W-1:0] epp_addr;
  logic [DATA_W-1:0] epp_wdata;
  logic              epp_ack;
  logic [DATA_W-1:0] epp_rdata;

  logic              f0_req;
  logic              f0_we;
  logic [ADDR_W-1:0] f0_addr;
  logic [DATA_W-1:0] f0_wdata;
  logic              f0_ack;
  logic [DATA_W-1:0] f0_rdata;

  logic              f1_req;
  logic              f1_we;
  logic [ADDR_W-1:0] f1_addr;
  logic [DATA_W-1:0] f1_wdata;
  logic              f1_ack;
  logic [DATA_W-1:0] f1_rdata;

  logic              busy;

  modport master (
    output epp_req, epp_we, epp_addr, epp_wdata,
    output f0_req, f0_we, f0_addr, f0_wdata,
    output f1_req, f1_we, f1_addr, f1_wdata,
    input  epp_ack, epp_rdata, f0_ack, f0_rdata, f1_ack, f1_rdata, busy
  );

  modport slave (
    input  epp_req, epp_we, epp_addr, epp_wdata,
    input  f0_req, f0_we, f0_addr, f0_wdata,
    input  f1_req, f1_we, f1_addr, f1_wdata,
    output epp_ack, epp_rdata, f0_ack, f0_rdata, f1_ack, f1_rdata, busy
  );
endinterface

// File: rtl/epp_reg_arbiter.sv
// Small register file shared by the EPP engine (priority, burst-limited) and
// two round-robin fabric masters through an IDLE -> ACCESS -> ACK sequence.
module epp_reg_arbiter #(
  parameter int ADDR_W        = 2,
  parameter int DATA_W        = 8,
  parameter int EPP_BURST_MAX = 4
) (
  input logic               clk,
  input logic               rst,
  epp_reg_arbiter_if.slave  bus
);
  localparam int         NREG      = 2 ** ADDR_W;
  localparam logic [3:0] BURST_MAX = 4'(EPP_BURST_MAX);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK} state_t;
  typedef enum logic [1:0] {W_EPP, W_F0, W_F1, W_NONE} win_t;

  state_t            state, state_nxt;
  win_t              win_sel, win_p0;
  logic              we_sel, we_p0;
  logic [ADDR_W-1:0] addr_sel, addr_p0;
  logic [DATA_W-1:0] wdata_sel, wdata_p0;
  logic [3:0]        cnt;
  logic              last_fab;
  logic              fab_pend;
  logic [DATA_W-1:0] rf [NREG];
  logic [DATA_W-1:0] epp_rdata_q, f0_rdata_q, f1_rdata_q;

  function automatic logic [3:0] cnt_sat_inc(input logic [3:0] c);
    return (c >= BURST_MAX) ? BURST_MAX : c + 4'd1;
  endfunction

  // Arbitration: EPP first unless the fabric has waited a full burst.
  always_comb begin
    fab_pend  = bus.f0_req | bus.f1_req;
    win_sel   = W_NONE;
    we_sel    = bus.epp_we;
    addr_sel  = bus.epp_addr;
    wdata_sel = bus.epp_wdata;
    if (bus.epp_req && !(fab_pend && cnt == BURST_MAX)) begin
      win_sel = W_EPP;
    end else if (bus.f0_req && (!bus.f1_req || last_fab)) begin
      win_sel   = W_F0;
      we_sel    = bus.f0_we;
      addr_sel  = bus.f0_addr;
      wdata_sel = bus.f0_wdata;
    end else if (bus.f1_req) begin
      win_sel   = W_F1;
      we_sel    = bus.f1_we;
      addr_sel  = bus.f1_addr;
      wdata_sel = bus.f1_wdata;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (win_sel != W_NONE) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = S_ACK;
      S_ACK:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      win_p0   <= W_NONE;
      cnt      <= 4'd0;
      last_fab <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && win_sel != W_NONE) begin
        win_p0 <= win_sel;
        if (win_sel == W_EPP) begin
          cnt <= fab_pend ? cnt_sat_inc(cnt) : 4'd0;
        end else begin
          cnt      <= 4'd0;
          last_fab <= (win_sel == W_F1);
        end
      end
    end
  end

  // Request capture stage: fields frozen for the rest of the transaction.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && win_sel != W_NONE) begin
      we_p0    <= we_sel;
      addr_p0  <= addr_sel;
      wdata_p0 <= wdata_sel;
    end
  end

  // Access stage: commit write or capture read into the winner's rdata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      epp_rdata_q <= '0;
      f0_rdata_q  <= '0;
      f1_rdata_q  <= '0;
    end else if (state == S_ACCESS) begin
      if (we_p0) begin
        rf[addr_p0] <= wdata_p0;
      end else if (win_p0 == W_EPP) begin
        epp_rdata_q <= rf[addr_p0];
      end else if (win_p0 == W_F0) begin
        f0_rdata_q <= rf[addr_p0];
      end else if (win_p0 == W_F1) begin
        f1_rdata_q <= rf[addr_p0];
      end
    end
  end

  assign bus.epp_ack   = (state == S_ACK) && (win_p0 == W_EPP);
  assign bus.f0_ack    = (state == S_ACK) && (win_p0 == W_F0);
  assign bus.f1_ack    = (state == S_ACK) && (win_p0 == W_F1);
  assign bus.epp_rdata = epp_rdata_q;
  assign bus.f0_rdata  = f0_rdata_q;
  assign bus.f1_rdata  = f1_rdata_q;
  assign bus.busy      = (state != S_IDLE);
endmodule

// File: tb/tb_epp_reg_arbiter.sv
// Directed bench for epp_reg_arbiter: handshake latency, priority, burst
// limit, round-robin, reset mid-transaction and idle hold behaviour.
module tb_epp_reg_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   errors  = 0;
  int   order [16];
  int   when  [16];

  epp_reg_arbiter_if #(.ADDR_W(2), .DATA_W(8)) bus ();

  epp_reg_arbiter #(.ADDR_W(2), .DATA_W(8), .EPP_BURST_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic ack_of(input int who);
    case (who)
      0:       return bus.epp_ack;
      1:       return bus.f0_ack;
      default: return bus.f1_ack;
    endcase
  endfunction

  function automatic logic [7:0] rdata_of(input int who);
    case (who)
      0:       return bus.epp_rdata;
      1:       return bus.f0_rdata;
      default: return bus.f1_rdata;
    endcase
  endfunction

  task automatic drive(input int who, input logic r, input logic we,
                       input logic [1:0] a, input logic [7:0] d);
    case (who)
      0: begin bus.epp_req = r; bus.epp_we = we; bus.epp_addr = a; bus.epp_wdata = d; end
      1: begin bus.f0_req  = r; bus.f0_we  = we; bus.f0_addr  = a; bus.f0_wdata  = d; end
      default: begin bus.f1_req = r; bus.f1_we = we; bus.f1_addr = a; bus.f1_wdata = d; end
    endcase
  endtask

  task automatic drop(input int who);
    case (who)
      0:       bus.epp_req = 1'b0;
      1:       bus.f0_req  = 1'b0;
      default: bus.f1_req  = 1'b0;
    endcase
  endtask

  // Single transaction: checks 2-cycle latency and a one-cycle ack pulse.
  task automatic xact(input string tag, input int who, input logic we,
                      input logic [1:0] a, input logic [7:0] d, output logic [7:0] rd);
    int  lat;
    bit  got;
    @(negedge clk);
    drive(who, 1'b1, we, a, d);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 12) begin
      @(negedge clk);
      lat++;
      if (ack_of(who)) got = 1'b1;
    end
    rd = rdata_of(who);
    drop(who);
    chk({tag, "_latency"}, lat, 2);
    @(negedge clk);
    chk({tag, "_ackpulse"}, {31'd0, ack_of(who)}, 0);
  endtask

  // Watch acks until n have been seen; records requester id and cycle.
  task automatic collect(input string tag, input int n, input bit drop_each);
    int cyc;
    int nacks;
    cyc   = 0;
    nacks = 0;
    while (nacks < n && cyc < 100) begin
      @(negedge clk);
      cyc++;
      for (int w = 0; w < 3; w++) begin
        if (ack_of(w) && nacks < 16) begin
          order[nacks] = w;
          when[nacks]  = cyc;
          nacks++;
          if (drop_each) drop(w);
        end
      end
    end
    if (nacks < n) chk({tag, "_timeout"}, nacks, n);
    drop(0); drop(1); drop(2);
  endtask

  initial begin
    logic [7:0] rd;
    int exp_order [10];
    drive(0, 1'b0, 1'b0, 2'd0, 8'h00);
    drive(1, 1'b0, 1'b0, 2'd0, 8'h00);
    drive(2, 1'b0, 1'b0, 2'd0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_acks", {29'd0, bus.epp_ack, bus.f0_ack, bus.f1_ack}, 0);
    chk("rst_rdata", {8'd0, bus.epp_rdata, bus.f0_rdata, bus.f1_rdata}, 0);

    // 1: EPP write then read
    xact("t1_wr", 0, 1'b1, 2'd2, 8'hA5, rd);
    chk("t1_wr_rdata_unchanged", rd, 8'h00);
    xact("t1_rd", 0, 1'b0, 2'd2, 8'h00, rd);
    chk("t1_rd_data", rd, 8'hA5);
    chk("t1_f0_rdata", bus.f0_rdata, 8'h00);
    chk("t1_f1_rdata", bus.f1_rdata, 8'h00);

    // 2: fabric round-robin
    xact("t2_pre0", 0, 1'b1, 2'd0, 8'h11, rd);
    xact("t2_pre1", 0, 1'b1, 2'd1, 8'h22, rd);
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 2'd0, 8'h00);
    drive(2, 1'b1, 1'b0, 2'd1, 8'h00);
    collect("t2", 4, 1'b0);
    for (int i = 0; i < 4; i++) chk($sformatf("t2_order%0d", i), order[i], (i % 2 == 0) ? 1 : 2);
    for (int i = 1; i < 4; i++) chk($sformatf("t2_gap%0d", i), when[i] - when[i-1], 3);
    chk("t2_f0_rdata", bus.f0_rdata, 8'h11);
    chk("t2_f1_rdata", bus.f1_rdata, 8'h22);

    // 3: EPP burst limit against a waiting f0
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 2'd3, 8'h77);
    drive(1, 1'b1, 1'b0, 2'd0, 8'h00);
    collect("t3", 10, 1'b0);
    exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    for (int i = 0; i < 10; i++) chk($sformatf("t3_order%0d", i), order[i], exp_order[i]);
    for (int i = 1; i < 10; i++) chk($sformatf("t3_gap%0d", i), when[i] - when[i-1], 3);
    chk("t3_f0_rdata", bus.f0_rdata, 8'h11);

    // 4: EPP and f1 together with cnt = 0, then read back f1's write
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 2'd2, 8'h00);
    drive(2, 1'b1, 1'b1, 2'd3, 8'h3C);
    collect("t4", 2, 1'b1);
    chk("t4_first", order[0], 0);
    chk("t4_second", order[1], 2);
    chk("t4_epp_rdata", bus.epp_rdata, 8'hA5);
    xact("t4_rd3", 0, 1'b0, 2'd3, 8'h00, rd);
    chk("t4_rd3_data", rd, 8'h3C);

    // 5: reset during ACCESS of an EPP write
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 2'd1, 8'hFF);
    @(negedge clk);
    chk("t5_busy_access", {31'd0, bus.busy}, 1);
    rst = 1'b1;
    drop(0);
    #1;
    chk("t5_busy_async", {31'd0, bus.busy}, 0);
    chk("t5_ack_async", {31'd0, bus.epp_ack}, 0);
    @(negedge clk);
    chk("t5_ack_in_rst", {31'd0, bus.epp_ack}, 0);
    rst = 1'b0;
    xact("t5_rd1", 0, 1'b0, 2'd1, 8'h00, rd);
    chk("t5_rd1_data", rd, 8'h00);
    xact("t5_wr0", 0, 1'b1, 2'd0, 8'h5A, rd);
    xact("t5_wr2", 0, 1'b1, 2'd2, 8'h6B, rd);
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 2'd0, 8'h00);
    drive(2, 1'b1, 1'b0, 2'd2, 8'h00);
    collect("t5", 2, 1'b1);
    chk("t5_rr_first", order[0], 1);
    chk("t5_rr_second", order[1], 2);
    chk("t5_f0_rdata", bus.f0_rdata, 8'h5A);
    chk("t5_f1_rdata", bus.f1_rdata, 8'h6B);
    xact("t5_rd2", 0, 1'b0, 2'd2, 8'h00, rd);
    chk("t5_rd2_data", rd, 8'h6B);

    // 6: idle hold
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("t6_idle%0d", i),
          {28'd0, bus.busy, bus.epp_ack, bus.f0_ack, bus.f1_ack}, 0);
    end
    chk("t6_epp_rdata", bus.epp_rdata, 8'h6B);
    chk("t6_f0_rdata", bus.f0_rdata, 8'h5A);
    chk("t6_f1_rdata", bus.f1_rdata, 8'h6B);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/epp_reg_arbiter.md
Name: epp_reg_arbiter

Overview:
- Owns a small 8-bit register file and shares its single access port among three requesters: the EPP host-side engine and two internal fabric masters (f0, f1).
- The EPP requester has priority. A starvation counter guarantees the fabric gets a slot during long EPP bursts.
- The two fabric requesters are served round-robin. Every requester uses the same req/ack handshake.

Parameters:
- ADDR_W, 2, register address width; the register file holds 2**ADDR_W registers.
- DATA_W, 8, register and data width.
- EPP_BURST_MAX, 4, maximum consecutive EPP grants while a fabric request is pending. Legal range 1..15.

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- epp_req  input  1  EPP requester transaction request
- epp_we  input  1  1 = write, 0 = read
- epp_addr  input  ADDR_W  register address
- epp_wdata  input  DATA_W  write data
- epp_ack  output  1  one-cycle transaction-complete pulse
- epp_rdata  output  DATA_W  read data, valid while epp_ack is high, held afterwards
- f0_req, f0_we, f0_addr, f0_wdata, f0_ack, f0_rdata  as epp_*, fabric master 0
- f1_req, f1_we, f1_addr, f1_wdata, f1_ack, f1_rdata  as epp_*, fabric master 1
- busy  output  1  high when the FSM is not in IDLE

Interface: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset (asynchronous, active-high, honoured at any time):
  - FSM goes to IDLE; all ack outputs 0; all rdata outputs 0; every register-file entry 0.
  - Starvation counter 0; round-robin pointer last_fab = 1, so f0 wins first.
- Handshake:
  - Requester raises req with we/addr/wdata stable and holds all of them until it sees ack.
  - req is sampled only in IDLE. If req is still high on the first IDLE edge after ack, that is a new transaction.
- FSM states (Moore), transitions on clk edges:
  - IDLE: if any req is high, choose a winner, latch winner id, we, addr and wdata, then go to ACCESS. Otherwise stay in IDLE.
  - ACCESS:
    - Write: commit wdata to regfile[addr].
    - Read: capture regfile[addr] into the winner's rdata register.
    - Then go to ACK.
  - ACK: winner's ack = 1 for exactly this cycle; all other acks 0. Then go to IDLE.
- Timing:
  - req high before edge E (FSM in IDLE) → ack high in the cycle after edge E+1.
  - One transaction per 3 cycles maximum.
  - A write is visible to a read granted in the next transaction.
- Read data:
  - rdata of each requester updates only on that requester's reads.
  - Writes leave rdata unchanged; other requesters' rdata is unaffected.
- Arbitration, evaluated in IDLE only; fab_pend = f0_req | f1_req:
  - EPP wins if epp_req && !(fab_pend && cnt == EPP_BURST_MAX).
  - Otherwise a fabric requester wins:
    - If only one fabric req is high, it wins.
    - If both are high, the one not equal to last_fab wins.
  - The pointer last_fab updates on every fabric grant.
- Starvation counter cnt (4-bit), updated on grants:
  - EPP grant with fab_pend high → cnt + 1, saturating at EPP_BURST_MAX.
  - EPP grant with fab_pend low → 0.
  - Fabric grant → 0.
- Simultaneous events:
  - A req rising during ACCESS/ACK waits for IDLE.
  - A requester dropping req before ack is an illegal protocol use; the latched transaction completes regardless.
- Reset mid-transaction:
  - Reset in ACCESS before the commit edge → write not committed.
  - Reset in ACK → ack drops immediately.
- busy = (state != IDLE).

Test Plan:
1. Reset, then EPP write addr 2 = 0xA5, then EPP read addr 2 → epp_ack pulses 1 cycle each, 2 cycles after req; epp_rdata = 0xA5; f0_rdata/f1_rdata stay 0x00.
2. f0 and f1 both request continuously (reads of addr 0/1, each pre-written with 0x11/0x22) → grants alternate f0, f1, f0, f1; f0_rdata = 0x11, f1_rdata = 0x22; one ack per 3 cycles.
3. epp_req held continuously (back-to-back writes) while f0_req held, EPP_BURST_MAX = 4 → grant order EPP ×4, f0, EPP ×4, f0; f0 never waits more than 4 EPP transactions.
4. epp_req and f1_req rise in the same cycle with cnt = 0 → EPP granted first, f1 next; f1 then writes 0x3C to addr 3 and an EPP read of addr 3 returns 0x3C.
5. EPP write addr 1 = 0xFF; assert rst for 1 cycle while busy = 1 and state = ACCESS → no ack, regfile[1] reads back 0x00, busy = 0 immediately, last_fab = 1.
6. All req low for 10 cycles after one completed read → busy = 0, all acks 0, rdata values held unchanged.
